// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong game controller.
// Holds the FSM state encoding, the signed coordinate type and all playfield geometry:
// field bounds, paddle x positions, ball/paddle sizes, centre coordinates and the
// limits derived from them.
package pong_game_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } game_state_e;

  // Signed so that a step past zero is seen as negative rather than wrapping.
  typedef logic signed [10:0] coord_t;

  localparam coord_t FieldXMin = 11'sd144;
  localparam coord_t FieldXMax = 11'sd784;
  localparam coord_t FieldYMin = 11'sd32;
  localparam coord_t FieldYMax = 11'sd511;

  localparam coord_t BallSize  = 11'sd8;
  localparam coord_t PadWidth  = 11'sd8;
  localparam coord_t PadHeight = 11'sd64;
  localparam coord_t PadLeftX  = 11'sd160;
  localparam coord_t PadRightX = 11'sd760;

  localparam coord_t CenterX  = 11'sd460;
  localparam coord_t CenterY  = 11'sd267;
  localparam coord_t PadInitY = 11'sd235;

  localparam coord_t BallYMax     = FieldYMax - BallSize;   // 503
  localparam coord_t BallXMax     = FieldXMax - BallSize;   // 776
  localparam coord_t PadYMax      = FieldYMax - PadHeight;  // 447
  localparam coord_t LeftBounceX  = PadLeftX + PadWidth;    // 168
  localparam coord_t RightBounceX = PadRightX - BallSize;   // 752

  localparam logic [7:0] ColBall = 8'hFF;
  localparam logic [7:0] ColPad  = 8'h1C;  // green = 7, red/blue = 0
  localparam logic [7:0] ColNone = 8'h00;

  function automatic logic in_rect(coord_t px, coord_t py, coord_t x, coord_t y,
                                   coord_t w, coord_t h);
    return (px >= x) && (px < x + w) && (py >= y) && (py < y + h);
  endfunction

  // Vertical overlap between the ball and a paddle whose top edge is pad_y.
  function automatic logic pad_overlap(coord_t ball_y, coord_t pad_y);
    return (ball_y + BallSize > pad_y) && (ball_y < pad_y + PadHeight);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Board-side bundle of the pong game controller.
// Inputs to the controller: VGA counters hc/vc, visible flag vidon and the five raw
// push buttons. Outputs: registered pixel colour red/green/blue, scores, FSM state.
// modport slave is the controller's view, modport master the driving environment's.
interface pong_game_ctrl_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       vidon;
  logic       btn_start;
  logic       btn_lu;
  logic       btn_ld;
  logic       btn_ru;
  logic       btn_rd;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [2:0] game_state;

  modport slave (
    input  hc, vc, vidon, btn_start, btn_lu, btn_ld, btn_ru, btn_rd,
    output red, green, blue, score_l, score_r, game_state
  );

  modport master (
    output hc, vc, vidon, btn_start, btn_lu, btn_ld, btn_ru, btn_rd,
    input  red, green, blue, score_l, score_r, game_state
  );
endinterface

// File: rtl/pong_game_ctrl_btn_sync.sv
// Push-button conditioner: 2-flop synchronizer followed by a rising-edge detector.
// Ports: clk, clr_n (async active-low), btn (raw asynchronous button),
//        level (synchronized level), rise (one-clock pulse on a synchronized 0->1).
module btn_sync (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  // [1:0] is the synchronizer, [2] remembers the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], btn};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller.
// Ports: clk (pixel clock), clr_n (async active-low reset), bus (pong_game_ctrl_if.slave:
// VGA counters, visible flag and raw buttons in; registered colour, scores and state out).
// Game state advances once per frame, on the clock after hc==0 && vc==0. The colour
// output is a one-clock registered lookup of the current ball and paddle positions.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int BALL_SPEED   = 2,
  parameter int PAD_SPEED    = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input logic             clk,
  input logic             clr_n,
  pong_game_ctrl_if.slave bus
);

  localparam int unsigned    CntW     = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SERVE_FRAMES - 1);
  localparam logic [3:0]     WinScore = 4'(WIN_SCORE);
  localparam coord_t         BallStep = coord_t'(BALL_SPEED);
  localparam coord_t         PadStep  = coord_t'(PAD_SPEED);

  localparam int BtnStart = 0;
  localparam int BtnLu    = 1;
  localparam int BtnLd    = 2;
  localparam int BtnRu    = 3;
  localparam int BtnRd    = 4;

  // Buttons
  logic [4:0] btn_raw, btn_level, btn_rise;

  assign btn_raw = {bus.btn_rd, bus.btn_ru, bus.btn_ld, bus.btn_lu, bus.btn_start};

  for (genvar i = 0; i < 5; i++) begin : g_btn_sync
    btn_sync u_btn_sync (
      .clk  (clk),
      .clr_n(clr_n),
      .btn  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (btn_rise[i])
    );
  end

  // Only the start button needs an edge; paddles use the held level.
  logic unused_btn;
  assign unused_btn = ^{btn_level[BtnStart], btn_rise[BtnRd:BtnLu]};

  // Game registers
  game_state_e     state_q;
  coord_t          bx_q, by_q, lpy_q, rpy_q;
  logic            dx_neg_q, dy_neg_q;
  logic [3:0]      score_l_q, score_r_q;
  logic [CntW-1:0] cnt_q;
  logic            frame_tick_q;
  logic            start_pend_q;
  logic [7:0]      colour_q;

  // Combinational next-frame values
  coord_t     bx_nxt, by_nxt, lpy_nxt, rpy_nxt, pix_x, pix_y;
  logic       hit_l, hit_r, miss_l, miss_r, start_evt;
  logic [7:0] colour_d;

  function automatic coord_t pad_next(coord_t top, logic up, logic dn);
    coord_t t;
    t = top;
    if (up && !dn) begin
      t = top - PadStep;
      if (t < FieldYMin) t = FieldYMin;
    end else if (dn && !up) begin
      t = top + PadStep;
      if (t > PadYMax) t = PadYMax;
    end
    return t;
  endfunction

  always_comb begin
    bx_nxt  = dx_neg_q ? bx_q - BallStep : bx_q + BallStep;
    by_nxt  = dy_neg_q ? by_q - BallStep : by_q + BallStep;
    hit_l   = dx_neg_q && (bx_nxt <= LeftBounceX) && pad_overlap(by_q, lpy_q);
    hit_r   = !dx_neg_q && (bx_nxt + BallSize >= PadRightX) && pad_overlap(by_q, rpy_q);
    miss_l  = bx_nxt < FieldXMin;
    miss_r  = bx_nxt > BallXMax;
    lpy_nxt = pad_next(lpy_q, btn_level[BtnLu], btn_level[BtnLd]);
    rpy_nxt = pad_next(rpy_q, btn_level[BtnRu], btn_level[BtnRd]);
    // A start edge seen between frames is held until the next frame tick.
    start_evt = start_pend_q | btn_rise[BtnStart];
  end

  always_comb begin
    pix_x    = $signed({1'b0, bus.hc});
    pix_y    = $signed({1'b0, bus.vc});
    colour_d = ColNone;
    if (bus.vidon) begin
      if (in_rect(pix_x, pix_y, bx_q, by_q, BallSize, BallSize)) begin
        colour_d = ColBall;
      end else if (in_rect(pix_x, pix_y, PadLeftX, lpy_q, PadWidth, PadHeight) ||
                   in_rect(pix_x, pix_y, PadRightX, rpy_q, PadWidth, PadHeight)) begin
        colour_d = ColPad;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      frame_tick_q <= 1'b0;
      start_pend_q <= 1'b0;
      colour_q     <= ColNone;
    end else begin
      frame_tick_q <= (bus.hc == 10'd0) && (bus.vc == 10'd0);
      start_pend_q <= frame_tick_q ? 1'b0 : start_evt;
      colour_q     <= colour_d;
    end
  end

  // Game FSM with ball, paddles, scores and serve counter.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= StIdle;
      bx_q      <= CenterX;
      by_q      <= CenterY;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
      lpy_q     <= PadInitY;
      rpy_q     <= PadInitY;
      score_l_q <= '0;
      score_r_q <= '0;
      cnt_q     <= '0;
    end else if (frame_tick_q) begin
      lpy_q <= lpy_nxt;
      rpy_q <= rpy_nxt;
      case (state_q)
        StIdle: begin
          score_l_q <= '0;
          score_r_q <= '0;
          bx_q      <= CenterX;
          by_q      <= CenterY;
          cnt_q     <= '0;
          if (start_evt) state_q <= StServe;
        end
        StServe: begin
          bx_q <= CenterX;
          by_q <= CenterY;
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StPlay;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPlay: begin
          if (by_nxt < FieldYMin) begin
            by_q     <= FieldYMin;
            dy_neg_q <= 1'b0;
          end else if (by_nxt > BallYMax) begin
            by_q     <= BallYMax;
            dy_neg_q <= 1'b1;
          end else begin
            by_q <= by_nxt;
          end
          // A paddle hit wins over a miss decided in the same frame.
          if (hit_l) begin
            bx_q     <= LeftBounceX;
            dx_neg_q <= 1'b0;
          end else if (hit_r) begin
            bx_q     <= RightBounceX;
            dx_neg_q <= 1'b1;
          end else begin
            bx_q <= bx_nxt;
            if (miss_l) begin
              score_r_q <= score_r_q + 4'd1;
              state_q   <= StPoint;
            end else if (miss_r) begin
              score_l_q <= score_l_q + 4'd1;
              state_q   <= StPoint;
            end
          end
        end
        StPoint: begin
          bx_q  <= CenterX;
          by_q  <= CenterY;
          cnt_q <= '0;
          if ((score_l_q == WinScore) || (score_r_q == WinScore)) begin
            state_q <= StOver;
          end else begin
            state_q  <= StServe;
            // The ball left through the loser's side; serve back toward that player.
            dx_neg_q <= (bx_q < CenterX);
          end
        end
        StOver: begin
          if (start_evt) begin
            state_q   <= StIdle;
            score_l_q <= '0;
            score_r_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.red        = colour_q[7:5];
  assign bus.green      = colour_q[4:2];
  assign bus.blue       = colour_q[1:0];
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.game_state = state_q;

endmodule
